// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard detection unit:
//   - hazard_state_e : stall FSM states (RUN, STALL)
//   - REG_ZERO       : the hard-wired zero register, never a real dependency
//   - STALL_MAX      : longest stall the unit can request, in cycles
//   - REMAIN_W       : width of the remaining-stall-cycles register
//   - regMatch()     : dependency test of one destination register against
//                      the operands of the instruction sitting in ID
// ---------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hazard_state_e;

    localparam logic [4:0] REG_ZERO  = 5'd0;
    localparam int         STALL_MAX = 2;
    localparam int         REMAIN_W  = (STALL_MAX > 2) ? $clog2(STALL_MAX) : 1;

    typedef logic [REMAIN_W-1:0] remain_t;

    // A write to $0 is discarded by the register file, so it can never create
    // a dependency. rt only counts when the ID instruction actually reads it.
    function automatic logic regMatch(input logic [4:0] dstReg,
                                      input logic [4:0] rsReg,
                                      input logic [4:0] rtReg,
                                      input logic       usesRt);
        return (dstReg != REG_ZERO) &&
               ((dstReg == rsReg) || (usesRt && (dstReg == rtReg)));
    endfunction

endpackage

// File: rtl/hazard_detection_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for the hazard unit's statistics.
// Ports:
//   clk     : clock, rising edge
//   rstn    : asynchronous active-low reset, clears the count
//   inc_i   : count one event this cycle
//   clr_i   : synchronous clear, wins over inc_i
//   count_o : current count, sticks at all-ones
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear has priority; once all-ones is reached further events are dropped
    // so the counter never wraps back to a misleadingly small value.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_detection.sv
// ---------------------------------------------------------------------------
// hazard_detection
// Detects the hazards forwarding cannot cover (load-use against EX, and
// ID-stage branch compares against EX/MEM), stalls the front end for one or
// two cycles and flushes IF/ID behind a taken branch.
// Ports:
//   clk, rstn               : clock (rising edge), async active-low reset
//   IF_ID_rs/rt/uses_rt     : source operands of the instruction in ID
//   ID_branch/_taken        : ID-stage branch and its (forwarded) outcome
//   ID_EX_mem_read/reg_write/rd : instruction currently in EX
//   EX_MEM_mem_read/rd      : instruction currently in MEM
//   pc_write, IF_ID_write   : front-end write enables (0 while stalling)
//   ID_EX_bubble            : insert a bubble into ID/EX
//   IF_ID_flush             : squash the wrong-path fetch behind a taken branch
//   stalled                 : FSM is holding a multi-cycle stall (debug)
// Optional build macro HAZARD_STATS_EN adds:
//   stats_clr               : synchronous clear of both statistics counters
//   stall_cycles            : saturating count of stalled cycles
//   flush_count             : saturating count of IF/ID flushes
// ---------------------------------------------------------------------------
module hazard_detection
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       IF_ID_rs,
    input  logic [4:0]       IF_ID_rt,
    input  logic             IF_ID_uses_rt,
    input  logic             ID_branch,
    input  logic             ID_branch_taken,
    input  logic             ID_EX_mem_read,
    input  logic             ID_EX_reg_write,
    input  logic [4:0]       ID_EX_rd,
    input  logic             EX_MEM_mem_read,
    input  logic [4:0]       EX_MEM_rd,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             ID_EX_bubble,
    output logic             IF_ID_flush,
`ifdef HAZARD_STATS_EN
    input  logic             stats_clr,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
`endif
    output logic             stalled
);

    hazard_state_e state_q;
    hazard_state_e state_d;
    remain_t       remain_q;
    remain_t       remain_d;

    logic exHit;
    logic memHit;
    logic needTwo;
    logic needAny;
    logic stallNow;

    // Counters narrower than one bit make no sense; reject at elaboration.
    if (CNT_W < 1) begin : g_badCntWidth
        $error("hazard_detection: CNT_W must be at least 1");
    end

    assign exHit  = regMatch(ID_EX_rd,  IF_ID_rs, IF_ID_rt, IF_ID_uses_rt);
    assign memHit = regMatch(EX_MEM_rd, IF_ID_rs, IF_ID_rt, IF_ID_uses_rt);

    // A branch compared in ID needs a loaded value two stages further on, so
    // a load in EX feeding it costs two cycles. Every other unresolvable case
    // (plain load-use, ALU result in EX feeding a branch, load in MEM feeding
    // a branch) costs one. An ALU result in EX feeding a non-branch is
    // handled by forwarding and is deliberately absent here.
    assign needTwo = ID_branch & ID_EX_mem_read & exHit;
    assign needAny = (ID_EX_mem_read & exHit)
                   | (ID_branch & ID_EX_reg_write & ~ID_EX_mem_read & exHit)
                   | (ID_branch & EX_MEM_mem_read & memHit);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= RUN;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
        end
    end

    // Next-state logic. One-cycle stalls never leave RUN; only the two-cycle
    // case parks in STALL, counting down the cycles still owed after the
    // detection cycle.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        case (state_q)
            RUN: begin
                if (needTwo) begin
                    state_d  = STALL;
                    remain_d = remain_t'(STALL_MAX - 1);
                end
            end
            STALL: begin
                remain_d = remain_q - 1'b1;
                if (remain_q == remain_t'(1)) begin
                    state_d  = RUN;
                    remain_d = '0;
                end
            end
            default: begin
                state_d  = RUN;
                remain_d = '0;
            end
        endcase
    end

    // Output logic. The stall must bite in the very cycle the hazard is
    // seen, so it is purely combinational. A hazarded taken branch holds its
    // flush until the stall has released it.
    always_comb begin
        stallNow     = ((state_q == RUN) && needAny) || (state_q == STALL);
        pc_write     = ~stallNow;
        IF_ID_write  = ~stallNow;
        ID_EX_bubble = stallNow;
        IF_ID_flush  = ID_branch & ID_branch_taken & ~stallNow;
        stalled      = (state_q == STALL);
    end

`ifdef HAZARD_STATS_EN
    sat_counter #(
        .W (CNT_W)
    ) uStallCounter (
        .clk     (clk),
        .rstn    (rstn),
        .inc_i   (stallNow),
        .clr_i   (stats_clr),
        .count_o (stall_cycles)
    );

    sat_counter #(
        .W (CNT_W)
    ) uFlushCounter (
        .clk     (clk),
        .rstn    (rstn),
        .inc_i   (IF_ID_flush),
        .clr_i   (stats_clr),
        .count_o (flush_count)
    );
`endif

endmodule
